// File: rtl/divider.sv
// Sequential restoring shift-subtract divider, one quotient bit per clock, MSB first.
// Define DIVIDER_ZERO_CHECK_EN to short-circuit a zero divisor straight to DONE with div_by_zero set.
module divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] prem;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] prem_next;
    logic [WIDTH-1:0] shift_q_next;
    logic             accept;
    logic             zero_skip;
    logic             last;

`ifdef DIVIDER_ZERO_CHECK_EN
    logic dbz_r;
`endif

    // The partial remainder stays below the divisor, so WIDTH+1 bits hold the
    // shifted value and the trial difference's sign bit is exact.
    always_comb begin
        accept       = start && (state != RUN);
        last         = (count == CW'(WIDTH - 1));
`ifdef DIVIDER_ZERO_CHECK_EN
        zero_skip    = accept && (divisor == '0);
`else
        zero_skip    = 1'b0;
`endif
        shifted      = {prem, shift_q[WIDTH-1]};
        trial        = shifted - {1'b0, divisor_r};
        qbit         = ~trial[WIDTH];
        prem_next    = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        shift_q_next = {shift_q[WIDTH-2:0], qbit};
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (last) state_next = DONE;
            default: state_next = accept ? (zero_skip ? DONE : RUN) : IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // shift_q starts as the dividend and fills with quotient bits as it shifts out.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            divisor_r <= '0;
            shift_q   <= '0;
            prem      <= '0;
            quot      <= '0;
            rem       <= '0;
`ifdef DIVIDER_ZERO_CHECK_EN
            dbz_r     <= 1'b0;
`endif
        end else if (accept) begin
            count     <= '0;
            divisor_r <= divisor;
            shift_q   <= dividend;
            prem      <= '0;
`ifdef DIVIDER_ZERO_CHECK_EN
            dbz_r     <= zero_skip;
            if (zero_skip) begin
                quot <= '1;
                rem  <= dividend;
            end
`endif
        end else if (state == RUN) begin
            count   <= count + CW'(1);
            prem    <= prem_next;
            shift_q <= shift_q_next;
            if (last) begin
                quot <= shift_q_next;
                rem  <= prem_next;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

`ifdef DIVIDER_ZERO_CHECK_EN
    assign div_by_zero = dbz_r && (state == DONE);
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider (WIDTH=8): directed cases plus randomized traffic
// compared every cycle against a timeline model built on plain / and %.
module tb_divider;

    localparam int WIDTH = 8;
`ifdef DIVIDER_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 1'b0;

    divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quot        (quot),
        .rem         (rem),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] expQuot(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (b == 0) ? {WIDTH{1'b1}} : WIDTH'(int'(a) / int'(b));
    endfunction

    function automatic logic [WIDTH-1:0] expRem(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (b == 0) ? a : WIDTH'(int'(a) % int'(b));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an accepted request produces its result WIDTH cycles later.
    logic             m_busy, m_done, m_dbz;
    logic [WIDTH-1:0] m_quot, m_rem, p_quot, p_rem;
    int               m_left;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
            m_quot <= '0;   m_rem  <= '0;   m_left <= 0;
            p_quot <= '0;   p_rem  <= '0;
        end else begin
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_quot <= p_quot;
                    m_rem  <= p_rem;
                end
            end else if (start) begin
                p_quot <= expQuot(dividend, divisor);
                p_rem  <= expRem(dividend, divisor);
                if (ZC && divisor == 0) begin
                    m_done <= 1'b1;
                    m_dbz  <= 1'b1;
                    m_quot <= expQuot(dividend, divisor);
                    m_rem  <= expRem(dividend, divisor);
                end else begin
                    m_busy <= 1'b1;
                    m_left <= WIDTH;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busy", 32'(busy), 32'(m_busy));
            checkOutput("done", 32'(done), 32'(m_done));
            checkOutput("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
            checkOutput("quot", 32'(quot), 32'(m_quot));
            checkOutput("rem", 32'(rem), 32'(m_rem));
        end
    end

    // Called at a negedge; start is seen by exactly one rising edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
    endtask

    task automatic waitDone(output int lat, output int busyCycles, input bit noise);
        lat = 1;
        busyCycles = 0;
        while (!done && lat < 40) begin
            if (busy) busyCycles++;
            if (noise) begin
                start    = 1'($urandom);
                dividend = WIDTH'($urandom);
                divisor  = WIDTH'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!done) checkOutput("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic runCase(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er);
        int lat, bc;
        applyStimulus(a, b);
        waitDone(lat, bc, 1'b0);
        checkOutput({name, "_latency"}, 32'(lat), 32'd9);
        checkOutput({name, "_quot"}, 32'(quot), 32'(eq));
        checkOutput({name, "_rem"}, 32'(rem), 32'(er));
    endtask

    initial begin
        int lat, bc;
        logic [WIDTH-1:0] a, b;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkEn = 1'b1;
        checkOutput("reset_quot", 32'(quot), 32'd0);
        checkOutput("reset_rem", 32'(rem), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;

        // First request straight out of reset.
        applyStimulus(8'd100, 8'd7);
        waitDone(lat, bc, 1'b0);
        checkOutput("basic_latency", 32'(lat), 32'd9);
        checkOutput("basic_busy_cycles", 32'(bc), 32'd8);
        checkOutput("basic_quot", 32'(quot), 32'd14);
        checkOutput("basic_rem", 32'(rem), 32'd2);
        checkOutput("basic_dbz", 32'(div_by_zero), 32'd0);

        // Back-to-back: each new start lands in the previous DONE cycle.
        runCase("b2b_255_1", 8'd255, 8'd1, 8'd255, 8'd0);
        runCase("b2b_5_9", 8'd5, 8'd9, 8'd0, 8'd5);
        runCase("b2b_200_200", 8'd200, 8'd200, 8'd1, 8'd0);
        repeat (2) @(negedge clk);

        // start held high with operands changing mid-run.
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(negedge clk);
        lat = 1;
        while (!done && lat < 40) begin
            dividend = 8'd50; divisor = 8'd3;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checkOutput("hold_latency", 32'(lat), 32'd9);
        checkOutput("hold_quot", 32'(quot), 32'd14);
        checkOutput("hold_rem", 32'(rem), 32'd2);
        @(negedge clk);
        checkOutput("hold_no_extra_done", 32'(done), 32'd0);

        // Zero divisor.
        applyStimulus(8'd42, 8'd0);
        waitDone(lat, bc, 1'b0);
        checkOutput("zero_latency", 32'(lat), ZC ? 32'd1 : 32'd9);
        checkOutput("zero_busy_cycles", 32'(bc), ZC ? 32'd0 : 32'd8);
        checkOutput("zero_quot", 32'(quot), 32'd255);
        checkOutput("zero_rem", 32'(rem), 32'd42);
        checkOutput("zero_dbz", 32'(div_by_zero), 32'(ZC));
        @(negedge clk);

        // Reset four cycles into a run.
        applyStimulus(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_quot", 32'(quot), 32'd0);
        checkOutput("midrst_rem", 32'(rem), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        applyStimulus(8'd9, 8'd2);
        waitDone(lat, bc, 1'b0);
        checkOutput("midrst_latency", 32'(lat), 32'd9);
        checkOutput("after_rst_quot", 32'(quot), 32'd4);
        checkOutput("after_rst_rem", 32'(rem), 32'd1);

        // Randomized traffic with ignored starts injected while busy.
        for (int i = 0; i < 1500; i++) begin
            a = WIDTH'($urandom);
            b = ($urandom_range(0, 15) == 0) ? '0 : WIDTH'($urandom_range(1, 255));
            applyStimulus(a, b);
            waitDone(lat, bc, 1'($urandom));
            checkOutput("rand_latency", 32'(lat), (ZC && b == 0) ? 32'd1 : 32'd9);
            checkOutput("rand_quot", 32'(quot), 32'(expQuot(a, b)));
            checkOutput("rand_rem", 32'(rem), 32'(expRem(a, b)));
            if (b != 0) begin
                checkOutput("rand_identity", 32'(quot) * 32'(b) + 32'(rem), 32'(a));
                checkOutput("rand_rem_lt_div", 32'(rem < b), 32'd1);
            end
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
